// File: rtl/axis_loopback_pkg.sv
// Shared types and helpers for the AXI-Stream loopback FIFO.
package axis_loopback_pkg;

    typedef enum logic {
        ACCEPT = 1'b0,
        DROP   = 1'b1
    } wr_state_e;

    // Pointer width: address bits plus one wrap bit to tell full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_loopback_ram.sv
// Beat storage: one synchronous write port, one combinational read port, not cleared on reset.
module axis_loopback_ram
    import axis_loopback_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 73,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk156,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk156) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_loopback_fifo.sv
// AXI-Stream TX->RX loopback through an on-chip FIFO, cut-through or store-and-forward,
// with whole-frame drop of frames too long to ever commit.
module axis_loopback_fifo
    import axis_loopback_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int KEEP_W    = DATA_W / 8,
    parameter int DEPTH     = 16,
    parameter int STORE_FWD = 0,
    parameter int CNT_W     = 32
) (
    input  logic                   clk156,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      tx_axis_tdata,
    input  logic [KEEP_W-1:0]      tx_axis_tkeep,
    input  logic                   tx_axis_tvalid,
    output logic                   tx_axis_tready,
    input  logic                   tx_axis_tlast,
    output logic [DATA_W-1:0]      rx_axis_tdata,
    output logic [KEEP_W-1:0]      rx_axis_tkeep,
    output logic                   rx_axis_tlast,
    output logic                   rx_axis_tvalid,
    input  logic                   rx_axis_tready,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic [CNT_W-1:0]       tx_frame_cnt,
    output logic [CNT_W-1:0]       rx_frame_cnt,
    output logic [CNT_W-1:0]       drop_frame_cnt
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr, used;
    logic [PW-1:0] wr_nxt, cm_nxt;
    wr_state_e     state, state_nxt;
    beat_t         wr_beat, rd_beat;
    logic          full, tx_fire, wr_en, rd_fire, drop_start, drop_end;

    assign used     = wr_ptr - rd_ptr;
    assign full     = (used == PW'(DEPTH));
    // Ready comes from local state only, so there is no combinational TX<->RX path.
    assign tx_axis_tready = !reset && ((state == DROP) || !full);
    assign tx_fire  = tx_axis_tvalid && tx_axis_tready;
    assign wr_en    = tx_fire && (state == ACCEPT);
    assign drop_end = tx_fire && (state == DROP) && tx_axis_tlast;

    assign rx_axis_tvalid = (cm_ptr != rd_ptr);
    assign rd_fire        = rx_axis_tvalid && rx_axis_tready;

    always_comb begin
        state_nxt  = state;
        drop_start = 1'b0;
        case (state)
            ACCEPT: begin
                // An open frame filling every entry can never commit: discard it.
                if ((STORE_FWD != 0) && full && (cm_ptr == rd_ptr)) begin
                    state_nxt  = DROP;
                    drop_start = 1'b1;
                end
            end
            DROP: begin
                if (drop_end) state_nxt = ACCEPT;
            end
            default: state_nxt = ACCEPT;
        endcase
    end

    always_comb begin
        wr_nxt = wr_ptr;
        if (drop_start)  wr_nxt = cm_ptr;
        else if (wr_en)  wr_nxt = wr_ptr + PW'(1);
    end

    always_comb begin
        cm_nxt = cm_ptr;
        if (STORE_FWD == 0)                  cm_nxt = wr_nxt;
        else if (wr_en && tx_axis_tlast)     cm_nxt = wr_ptr + PW'(1);
    end

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            state          <= ACCEPT;
            wr_ptr         <= '0;
            cm_ptr         <= '0;
            rd_ptr         <= '0;
            tx_frame_cnt   <= '0;
            rx_frame_cnt   <= '0;
            drop_frame_cnt <= '0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_nxt;
            cm_ptr <= cm_nxt;
            if (rd_fire)                 rd_ptr         <= rd_ptr + PW'(1);
            if (wr_en && tx_axis_tlast)  tx_frame_cnt   <= tx_frame_cnt + CNT_W'(1);
            if (rd_fire && rd_beat.last) rx_frame_cnt   <= rx_frame_cnt + CNT_W'(1);
            if (drop_end)                drop_frame_cnt <= drop_frame_cnt + CNT_W'(1);
        end
    end

    assign wr_beat = '{data: tx_axis_tdata, keep: tx_axis_tkeep, last: tx_axis_tlast};

    axis_loopback_ram #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(beat_t))
    ) u_ram (
        .clk156 (clk156),
        .we     (wr_en),
        .waddr  (wr_ptr[AW-1:0]),
        .wdata  (wr_beat),
        .raddr  (rd_ptr[AW-1:0]),
        .rdata  (rd_beat)
    );

    assign rx_axis_tdata = rd_beat.data;
    assign rx_axis_tkeep = rd_beat.keep;
    assign rx_axis_tlast = rd_beat.last;
    assign fill_level    = used;

endmodule
